// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared opcodes, immediate formats, FSM states and datapath select codes
//   for the multicycle RV32I controller.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_EXEC_R  = 4'd2;
    localparam logic [3:0] S_EXEC_I  = 4'd3;
    localparam logic [3:0] S_ALU_WB  = 4'd4;
    localparam logic [3:0] S_MEM_ADR = 4'd5;
    localparam logic [3:0] S_MEM_RD  = 4'd6;
    localparam logic [3:0] S_LD_WB   = 4'd7;
    localparam logic [3:0] S_MEM_WR  = 4'd8;
    localparam logic [3:0] S_BRANCH  = 4'd9;
    localparam logic [3:0] S_JAL     = 4'd10;
    localparam logic [3:0] S_JALR    = 4'd11;
    localparam logic [3:0] S_JALR_PC = 4'd12;
    localparam logic [3:0] S_JWB     = 4'd13;
    localparam logic [3:0] S_LUI     = 4'd14;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MDR    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    typedef struct packed {
        logic       memReq;
        logic       memWrite;
        logic       adrSrc;
        logic       irWrite;
        logic       pcWrite;
        logic       regWrite;
        logic [1:0] aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] resultSrc;
        logic [2:0] immSrc;
        logic       illegal;
    } ctrl_t;

    // Every supported opcode leaves DECODE for a non-FETCH state, so a FETCH
    // result doubles as the illegal-opcode indication.
    function automatic logic [3:0] decodeNext(input logic [6:0] op);
        case (op)
            OP_R:                decodeNext = S_EXEC_R;
            OP_I:                decodeNext = S_EXEC_I;
            OP_LOAD, OP_STORE:   decodeNext = S_MEM_ADR;
            OP_BRANCH:           decodeNext = S_BRANCH;
            OP_JAL:              decodeNext = S_JAL;
            OP_JALR:             decodeNext = S_JALR;
            OP_LUI:              decodeNext = S_LUI;
            default:             decodeNext = S_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/branch_cond.sv
// branch_cond: branch-taken decision from funct3 and ALU flags.
//   funct3 in 3 : branch type (000 beq, 001 bne, 100 blt, 101 bge)
//   zero   in 1 : ALU result == 0
//   lt     in 1 : ALU signed less-than
//   taken  out 1: branch condition satisfied (0 for unsupported funct3)
module branch_cond (
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    output logic       taken
);

    always_comb begin
        taken = (funct3 == 3'b000) ? zero :
                (funct3 == 3'b001) ? !zero :
                (funct3 == 3'b100) ? lt :
                (funct3 == 3'b101) ? !lt : 1'b0;
    end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: main FSM of the multicycle RV32I core.
//   clk, rst_n        : clock, asynchronous active-low reset
//   opcode, funct3    : instruction fields from IR
//   zero, lt          : ALU flags for branch resolution
//   mem_ready         : memory completes the current access
//   mem_req/mem_write/adr_src          : memory handshake and address select
//   ir_write/pc_write/reg_write        : state-element enables
//   alu_src_a/alu_src_b/alu_op/result_src/imm_src : datapath selects
//   illegal           : one-cycle pulse on unsupported opcode
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int IMM_W   = 3,
    parameter int STATE_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             lt,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       result_src,
    output logic [IMM_W-1:0] imm_src,
    output logic             illegal
);

    logic [STATE_W-1:0] state, nextState;
    ctrl_t              c, ctl;
    logic               taken;

    branch_cond uBranch (.funct3(funct3), .zero(zero), .lt(lt), .taken(taken));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= nextState;
    end

    always_comb begin
        nextState = S_FETCH;
        case (state)
            S_FETCH:             nextState = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:            nextState = decodeNext(opcode);
            S_EXEC_R, S_EXEC_I:  nextState = S_ALU_WB;
            S_MEM_ADR:           nextState = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:            nextState = mem_ready ? S_LD_WB : S_MEM_RD;
            S_MEM_WR:            nextState = mem_ready ? S_FETCH : S_MEM_WR;
            S_JAL, S_JALR_PC:    nextState = S_JWB;
            S_JALR:              nextState = S_JALR_PC;
            default:             nextState = S_FETCH;
        endcase
    end

    // In FETCH the IR/PC loads wait for mem_ready; BRANCH pc_write follows the
    // live flags. Everything else is a pure function of state and IR opcode.
    always_comb begin
        c = '0;
        case (state)
            S_FETCH: begin
                c.memReq    = 1'b1;
                c.irWrite   = mem_ready;
                c.pcWrite   = mem_ready;
                c.aluSrcB   = SRCB_FOUR;
                c.resultSrc = RES_ALU;
            end
            S_DECODE: begin
                c.aluSrcA = SRCA_OLDPC;
                c.aluSrcB = SRCB_IMM;
                c.immSrc  = IMM_B;
                c.illegal = (decodeNext(opcode) == S_FETCH);
            end
            S_EXEC_R: begin
                c.aluSrcA = SRCA_RS1;
                c.aluOp   = ALU_FUNCT;
            end
            S_EXEC_I: begin
                c.aluSrcA = SRCA_RS1;
                c.aluSrcB = SRCB_IMM;
                c.aluOp   = ALU_FUNCT;
            end
            S_ALU_WB:  c.regWrite = 1'b1;
            S_MEM_ADR: begin
                c.aluSrcA = SRCA_RS1;
                c.aluSrcB = SRCB_IMM;
                c.immSrc  = (opcode == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEM_RD: begin
                c.memReq = 1'b1;
                c.adrSrc = 1'b1;
            end
            S_LD_WB: begin
                c.resultSrc = RES_MDR;
                c.regWrite  = 1'b1;
            end
            S_MEM_WR: begin
                c.memReq   = 1'b1;
                c.memWrite = 1'b1;
                c.adrSrc   = 1'b1;
            end
            S_BRANCH: begin
                c.aluSrcA = SRCA_RS1;
                c.aluOp   = ALU_SUB;
                c.pcWrite = taken;
            end
            S_JAL: begin
                c.aluSrcA = SRCA_OLDPC;
                c.aluSrcB = SRCB_FOUR;
                c.immSrc  = IMM_J;
                c.pcWrite = 1'b1;
            end
            S_JALR: begin
                c.aluSrcA = SRCA_RS1;
                c.aluSrcB = SRCB_IMM;
            end
            S_JALR_PC: c.pcWrite = 1'b1;
            S_JWB: begin
                c.aluSrcA   = SRCA_OLDPC;
                c.aluSrcB   = SRCB_FOUR;
                c.resultSrc = RES_ALU;
                c.regWrite  = 1'b1;
            end
            S_LUI: begin
                c.immSrc    = IMM_U;
                c.resultSrc = RES_IMM;
                c.regWrite  = 1'b1;
            end
            default: c = '0;
        endcase
    end

    // Reset parks the FSM in FETCH, which would otherwise request memory;
    // gating keeps every output quiet for as long as rst_n is low.
    assign ctl        = rst_n ? c : '0;
    assign mem_req    = ctl.memReq;
    assign mem_write  = ctl.memWrite;
    assign adr_src    = ctl.adrSrc;
    assign ir_write   = ctl.irWrite;
    assign pc_write   = ctl.pcWrite;
    assign reg_write  = ctl.regWrite;
    assign alu_src_a  = ctl.aluSrcA;
    assign alu_src_b  = ctl.aluSrcB;
    assign alu_op     = ctl.aluOp;
    assign result_src = ctl.resultSrc;
    assign imm_src    = ctl.immSrc;
    assign illegal    = ctl.illegal;

endmodule
